// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with Gray-coded parallel load, sticky wrap flags and a wrap pulse.
// Define GRAY_BIN_OUT_EN to add the registered Binary output alongside Output.
module gray_counter_param #(
    parameter int unsigned      WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow,
    output logic             Underflow,
`ifdef GRAY_BIN_OUT_EN
    output logic             Wrap,
    output logic [WIDTH-1:0] Binary
`else
    output logic             Wrap
`endif
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [WIDTH-1:0] RST_BIN = gray2bin(RST_VAL);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic             up_wrap;
    logic             dn_wrap;
    logic             ovf_next;
    logic             unf_next;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        up_wrap  = 1'b0;
        dn_wrap  = 1'b0;
        if (Load) begin
            cnt_next = gray2bin(LoadVal);
        end else if (En) begin
            if (Dir) begin
                cnt_next = cnt + 1'b1;
                up_wrap  = (cnt == '1);
            end else begin
                cnt_next = cnt - 1'b1;
                dn_wrap  = (cnt == '0);
            end
        end
        // A wrap on the same edge as ClrFlags leaves its own flag set.
        ovf_next = (Overflow  & ~ClrFlags) | up_wrap;
        unf_next = (Underflow & ~ClrFlags) | dn_wrap;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt       <= RST_BIN;
            Output    <= RST_VAL;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Wrap      <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            Output    <= cnt_next ^ (cnt_next >> 1);
            Overflow  <= ovf_next;
            Underflow <= unf_next;
            Wrap      <= up_wrap | dn_wrap;
        end
    end

`ifdef GRAY_BIN_OUT_EN
    assign Binary = cnt;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: a 3-bit and a 4-bit instance driven with directed vectors.
// Binary is connected and checked only when GRAY_BIN_OUT_EN is defined.
module tb_gray_counter_param;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [3:0] b;
        logic       ov;
        logic       un;
        logic       wr;
        logic       onebit;
    } exp_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge Clk) cycle <= cycle + 1;

    exp_t q3[$];
    exp_t q4[$];

    logic       rst3, en3, dir3, load3, clr3, ov3, un3, wr3;
    logic [2:0] lv3, out3, bin3;
    logic       rst4, en4, dir4, load4, clr4, ov4, un4, wr4;
    logic [3:0] lv4, out4, bin4;

    gray_counter_param #(.WIDTH(3), .RST_VAL(3'b000)) dut3 (
        .Clk(Clk), .Reset(rst3), .En(en3), .Dir(dir3), .Load(load3), .LoadVal(lv3),
        .ClrFlags(clr3), .Output(out3), .Overflow(ov3), .Underflow(un3), .Wrap(wr3)
`ifdef GRAY_BIN_OUT_EN
        , .Binary(bin3)
`endif
    );

    gray_counter_param #(.WIDTH(4), .RST_VAL(4'b0000)) dut4 (
        .Clk(Clk), .Reset(rst4), .En(en4), .Dir(dir4), .Load(load4), .LoadVal(lv4),
        .ClrFlags(clr4), .Output(out4), .Overflow(ov4), .Underflow(un4), .Wrap(wr4)
`ifdef GRAY_BIN_OUT_EN
        , .Binary(bin4)
`endif
    );

`ifndef GRAY_BIN_OUT_EN
    assign bin3 = '0;
    assign bin4 = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [3:0] g, input logic [3:0] b,
                           input logic ov, input logic un, input logic wr);
        check($sformatf("%s output @%0d", tag, e.cyc), 32'(g), 32'(e.g));
        check($sformatf("%s overflow @%0d", tag, e.cyc), 32'(ov), 32'(e.ov));
        check($sformatf("%s underflow @%0d", tag, e.cyc), 32'(un), 32'(e.un));
        check($sformatf("%s wrap @%0d", tag, e.cyc), 32'(wr), 32'(e.wr));
`ifdef GRAY_BIN_OUT_EN
        check($sformatf("%s binary @%0d", tag, e.cyc), 32'(b), 32'(e.b));
`else
        if (b !== b) $display("unreachable");
`endif
    endtask

    // Monitors: pop every expectation whose target cycle has been reached.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #1;
            while (q3.size() > 0 && q3[0].cyc <= cycle) begin
                e = q3.pop_front();
                compare("dut3", e, {1'b0, out3}, {1'b0, bin3}, ov3, un3, wr3);
            end
        end
    end

    initial begin
        exp_t       e;
        logic [3:0] last;
        last = '0;
        forever begin
            @(negedge Clk);
            #1;
            while (q4.size() > 0 && q4[0].cyc <= cycle) begin
                e = q4.pop_front();
                compare("dut4", e, out4, bin4, ov4, un4, wr4);
                if (e.onebit) check($sformatf("dut4 one-bit step @%0d", e.cyc), $countones(out4 ^ last), 1);
                last = out4;
            end
        end
    end

    task automatic drv3(input logic en, input logic dir, input logic load, input logic [2:0] lv,
                        input logic clr, input logic [2:0] g, input logic [2:0] b,
                        input logic ov, input logic un, input logic wr);
        @(negedge Clk);
        en3 = en; dir3 = dir; load3 = load; lv3 = lv; clr3 = clr;
        q3.push_back('{cycle + 1, {1'b0, g}, {1'b0, b}, ov, un, wr, 1'b0});
    endtask

    task automatic drv4(input logic en, input logic dir, input logic load, input logic [3:0] lv,
                        input logic clr, input logic [3:0] g, input logic [3:0] b,
                        input logic ov, input logic un, input logic wr, input logic ob);
        @(negedge Clk);
        en4 = en; dir4 = dir; load4 = load; lv4 = lv; clr4 = clr;
        q4.push_back('{cycle + 1, g, b, ov, un, wr, ob});
    endtask

    logic [2:0] up3   [8]  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [3:0] up4   [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    initial begin
        rst3 = 1'b1; en3 = 1'b0; dir3 = 1'b0; load3 = 1'b0; lv3 = '0; clr3 = 1'b0;
        rst4 = 1'b1; en4 = 1'b0; dir4 = 1'b0; load4 = 1'b0; lv4 = '0; clr4 = 1'b0;
        @(negedge Clk);
        q3.push_back('{cycle, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
        q4.push_back('{cycle, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
        rst3 = 1'b0;
        rst4 = 1'b0;

        // 3-bit full up sweep; only the eighth edge wraps.
        for (int i = 0; i < 8; i++)
            drv3(1, 1, 0, 3'b000, 0, up3[i], 3'(i + 1), (i == 7), 0, (i == 7));
        drv3(0, 0, 0, 3'b000, 0, 3'b000, 3'd0, 1, 0, 0);
        drv3(0, 0, 0, 3'b000, 1, 3'b000, 3'd0, 0, 0, 0);
        drv3(1, 0, 0, 3'b000, 0, 3'b100, 3'd7, 0, 1, 1);
        drv3(0, 0, 0, 3'b000, 0, 3'b100, 3'd7, 0, 1, 0);
        // Direction change across the boundary: back-to-back wrap pulses.
        drv3(1, 1, 0, 3'b000, 0, 3'b000, 3'd0, 1, 1, 1);
        drv3(1, 0, 0, 3'b000, 0, 3'b100, 3'd7, 1, 1, 1);
        drv3(0, 0, 0, 3'b000, 0, 3'b100, 3'd7, 1, 1, 0);

        // 4-bit: load beats count, wrap beats ClrFlags, ClrFlags clears the other flag.
        drv4(1, 1, 1, 4'b1000, 0, 4'b1000, 4'd15, 0, 0, 0, 0);
        drv4(1, 1, 0, 4'b0000, 0, 4'b0000, 4'd0,  1, 0, 1, 0);
        drv4(0, 0, 1, 4'b1000, 0, 4'b1000, 4'd15, 1, 0, 0, 0);
        drv4(1, 1, 0, 4'b0000, 1, 4'b0000, 4'd0,  1, 0, 1, 0);
        drv4(0, 0, 0, 4'b0000, 1, 4'b0000, 4'd0,  0, 0, 0, 0);
        drv4(0, 0, 1, 4'b1000, 0, 4'b1000, 4'd15, 0, 0, 0, 0);
        drv4(1, 1, 0, 4'b0000, 0, 4'b0000, 4'd0,  1, 0, 1, 0);
        drv4(1, 0, 0, 4'b0000, 1, 4'b1000, 4'd15, 0, 1, 1, 0);
        drv4(0, 0, 1, 4'b0010, 0, 4'b0010, 4'd3,  0, 1, 0, 0);
        drv4(1, 1, 0, 4'b0000, 0, 4'b0110, 4'd4,  0, 1, 0, 0);

        // Asynchronous reset between edges while Output=0110 and Underflow=1.
        @(negedge Clk);
        #2;
        en4 = 1'b0;
        rst4 = 1'b1;
        #1;
        check("dut4 async reset output", 32'(out4), 32'h0);
        check("dut4 async reset overflow", 32'(ov4), 32'h0);
        check("dut4 async reset underflow", 32'(un4), 32'h0);
        check("dut4 async reset wrap", 32'(wr4), 32'h0);
        @(negedge Clk);
        rst4 = 1'b0;
        q4.push_back('{cycle, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});

        // Full 4-bit up sweep from reset, then one down step across the boundary.
        for (int i = 0; i < 16; i++)
            drv4(1, 1, 0, 4'b0000, 0, up4[i], 4'(i + 1), (i == 15), 0, (i == 15), 1);
        drv4(1, 0, 0, 4'b0000, 0, 4'b1000, 4'd15, 1, 1, 1, 1);
        drv4(0, 0, 0, 4'b0000, 0, 4'b1000, 4'd15, 1, 1, 0, 1'b0);

        for (int i = 0; i < 10 && (q3.size() > 0 || q4.size() > 0); i++) @(negedge Clk);
        #2;
        check("scoreboard drained", 32'(q3.size() + q4.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
